// File: rtl/voice_buf_pkg.sv
// voice_stream_buffer shared types: FSM state, address-width helper,
// saturation limit for the optional event counters.
package voice_buf_pkg;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } buf_state_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/voice_stream_buffer_if.sv
// voice_stream_buffer data-path bundle: producer write side, consumer
// pop side and flush. master = the block's user, slave = the buffer.
interface voice_stream_buffer_if #(
    parameter int W = 32
) ();

    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         rd_en;
    logic         flush;
    logic         out_valid;
    logic [W-1:0] out_data;

    modport master (
        output in_valid, in_data, rd_en, flush,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, rd_en, flush,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/voice_buf_ram.sv
// Simple dual-port RAM: one write port, one registered read port whose
// output register holds its value between reads.
module voice_buf_ram #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 32,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             sys_rst_n2,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge sys_rst_n2) begin
        if (sys_rst_n2) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/voice_stream_buffer.sv
// Lockstep multi-channel sample buffer with water-level hysteresis.
// Optional VOICE_STREAM_BUF_STATS_EN adds saturating ovf/udf counters.
module voice_stream_buffer
    import voice_buf_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2048,
    parameter int HI_MARK    = 2000,
    parameter int LO_MARK    = 0
) (
    input  logic                    clk,
    input  logic                    sys_rst_n2,
    voice_stream_buffer_if.slave    bus,
    output logic                    streaming,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    underrun
`ifdef VOICE_STREAM_BUF_STATS_EN
    ,
    output logic [15:0]             ovf_cnt,
    output logic [15:0]             udf_cnt
`endif
);

    localparam int AW = addr_w(DEPTH);
    localparam int LW = AW + 1;
    localparam int W  = NUM_CH * DATA_WIDTH;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] HI_L    = LW'(HI_MARK);
    localparam logic [LW-1:0] LO_L    = LW'(LO_MARK);
    localparam logic [LW-1:0] ONE_L   = LW'(1);

    if (!(LO_MARK < HI_MARK && HI_MARK <= DEPTH)) begin : g_bad_marks
        $error("voice_stream_buffer: need LO_MARK < HI_MARK <= DEPTH");
    end

    if ((1 << AW) != DEPTH) begin : g_bad_depth
        $error("voice_stream_buffer: DEPTH must be a power of 2");
    end

    buf_state_t    state;
    logic [LW-1:0] wptr;
    logic [LW-1:0] rptr;
    logic          full;
    logic          empty;
    logic          wr_fire;
    logic          pop;
    logic          udf_ev;
    logic          ovf_ev;

    assign level        = wptr - rptr;
    assign full         = (level == DEPTH_L);
    assign empty        = (level == '0);
    assign bus.in_ready = ~full;

    // Flush outranks everything: it swallows a same-cycle write and pop.
    assign wr_fire = bus.in_valid & ~full & ~bus.flush;
    assign ovf_ev  = bus.in_valid & full;
    assign pop     = bus.rd_en & (state == STREAM) & ~empty & ~bus.flush;
    assign udf_ev  = bus.rd_en & (state == STREAM) & empty & ~bus.flush;

    always_ff @(posedge clk or posedge sys_rst_n2) begin
        if (sys_rst_n2) begin
            wptr <= '0;
            rptr <= '0;
        end else if (bus.flush) begin
            rptr <= wptr;
        end else begin
            if (wr_fire) begin
                wptr <= wptr + ONE_L;
            end
            if (pop) begin
                rptr <= rptr + ONE_L;
            end
        end
    end

    always_ff @(posedge clk or posedge sys_rst_n2) begin
        if (sys_rst_n2) begin
            state     <= FILL;
            streaming <= 1'b0;
        end else if (bus.flush) begin
            state     <= FILL;
            streaming <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (level >= HI_L) begin
                        state     <= STREAM;
                        streaming <= 1'b1;
                    end
                end
                STREAM: begin
                    if (level <= LO_L) begin
                        state     <= FILL;
                        streaming <= 1'b0;
                    end
                end
                default: begin
                    state     <= FILL;
                    streaming <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge sys_rst_n2) begin
        if (sys_rst_n2) begin
            bus.out_valid <= 1'b0;
            overflow      <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            bus.out_valid <= pop;
            overflow      <= ovf_ev;
            underrun      <= udf_ev;
        end
    end

    voice_buf_ram #(
        .DEPTH (DEPTH),
        .WIDTH (W),
        .AW    (AW)
    ) u_ram (
        .clk        (clk),
        .sys_rst_n2 (sys_rst_n2),
        .we         (wr_fire),
        .waddr      (wptr[AW-1:0]),
        .wdata      (bus.in_data),
        .re         (pop),
        .raddr      (rptr[AW-1:0]),
        .rdata      (bus.out_data)
    );

`ifdef VOICE_STREAM_BUF_STATS_EN
    always_ff @(posedge clk or posedge sys_rst_n2) begin
        if (sys_rst_n2) begin
            ovf_cnt <= '0;
            udf_cnt <= '0;
        end else if (bus.flush) begin
            ovf_cnt <= '0;
            udf_cnt <= '0;
        end else begin
            if (ovf_ev && ovf_cnt != CNT_MAX) begin
                ovf_cnt <= ovf_cnt + 16'd1;
            end
            if (udf_ev && udf_cnt != CNT_MAX) begin
                udf_cnt <= udf_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
